controle_jogo: RTL and testbench

- Game sequencer between the keys, nave and memory blocks.
- Owns the game state: wait, playing, paused, hit and game over.
- Moves the enemy ball once per video frame and detects collisions: allied ball vs enemy ball, and enemy ball vs ship.
- Keeps lives and score, and drives reiniciarJogo (to nave) and perdeu (to memory).

---
 rtl/jogo_pkg.sv | 26 ++
 rtl/colisao_caixa.sv | 28 ++
 rtl/controle_jogo.sv | 160 ++++++++++++++++
 tb/tb_controle_jogo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - game states, screen geometry and gameplay constants for controle_jogo
package jogo_pkg;

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        JOGANDO  = 3'd1,
        PAUSADO  = 3'd2,
        ATINGIDO = 3'd3,
        FIM      = 3'd4
    } estado_t;

    localparam int LARGURA_TELA = 640;
    localparam int ALTURA_TELA  = 480;
    localparam int Y_TOPO       = 20;
    localparam int VEL_INIMIGA  = 2;
    localparam int VIDAS_INI    = 3;
    localparam int QUADROS_HIT  = 60;
    localparam int RAIO_INIMIGA = 5;
    localparam int PONTOS_MAX   = 999;
    localparam int VEL_MAX      = 8;

    // Respawn x lands in [2R, LARGURA_TELA-2R-1]
    localparam int FAIXA_X      = LARGURA_TELA - 4 * RAIO_INIMIGA;
    localparam int MARGEM_X     = 2 * RAIO_INIMIGA;

endpackage

// File: rtl/colisao_caixa.sv
// rtl/colisao_caixa.sv - combinational 11-bit point-vs-box overlap check
module colisao_caixa (
    input  logic [10:0] px,
    input  logic [10:0] py,
    input  logic [10:0] bx,
    input  logic [10:0] by,
    input  logic [10:0] margem,
    input  logic [10:0] alcance_x,
    input  logic [10:0] alcance_y,
    output logic        hit
);

    logic        x_ok;
    logic        y_ok;

    // Point left/above the box reference may reach back by margem; right/below by alcance
    always_comb begin
        x_ok = 1'b0;
        y_ok = 1'b0;
        if (px >= bx) x_ok = (px - bx) <= alcance_x;
        else          x_ok = (bx - px) <= margem;
        if (py >= by) y_ok = (py - by) <= alcance_y;
        else          y_ok = (by - py) <= margem;
    end

    assign hit = x_ok && y_ok;

endmodule

// File: rtl/controle_jogo.sv
// rtl/controle_jogo.sv - game sequencer; DIFICULDADE_PROGRESSIVA_EN enables score-based enemy speed
module controle_jogo
    import jogo_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       fim_quadro,
    input  logic       iniciar,
    input  logic       pausa,
    input  logic [9:0] x_bola_aliada,
    input  logic [9:0] y_bola_aliada,
    input  logic [9:0] raio_bola_aliada,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] largura_nave,
    input  logic [9:0] altura_nave,
    output logic [9:0] x_bola_inimiga,
    output logic [9:0] y_bola_inimiga,
    output logic [9:0] raio_bola_inimiga,
    output logic       reiniciarJogo,
    output logic       perdeu,
    output logic [1:0] vidas,
    output logic [9:0] pontos,
    output logic [2:0] estado
);

    localparam logic [10:0] RAIO_L   = 11'(RAIO_INIMIGA);
    localparam logic [10:0] Y_LIMITE = 11'(ALTURA_TELA - RAIO_INIMIGA);

    estado_t     est;
    logic [9:0]  lfsr;
    logic [5:0]  cnt_quadros;
    logic [10:0] soma_aliada;
    logic [10:0] vel;
    logic [10:0] y_soma;
    logic [9:0]  lfsr_mod;
    logic [9:0]  x_respawn;
    logic        hit_aliada;
    logic        hit_nave;

    assign soma_aliada = {1'b0, raio_bola_aliada} + RAIO_L;

    colisao_caixa u_col_aliada (
        .px        ({1'b0, x_bola_inimiga}),
        .py        ({1'b0, y_bola_inimiga}),
        .bx        ({1'b0, x_bola_aliada}),
        .by        ({1'b0, y_bola_aliada}),
        .margem    (soma_aliada),
        .alcance_x (soma_aliada),
        .alcance_y (soma_aliada),
        .hit       (hit_aliada)
    );

    colisao_caixa u_col_nave (
        .px        ({1'b0, x_bola_inimiga}),
        .py        ({1'b0, y_bola_inimiga}),
        .bx        ({1'b0, x_nave}),
        .by        ({1'b0, y_nave}),
        .margem    (RAIO_L),
        .alcance_x ({1'b0, largura_nave} + RAIO_L),
        .alcance_y ({1'b0, altura_nave} + RAIO_L),
        .hit       (hit_nave)
    );

`ifdef DIFICULDADE_PROGRESSIVA_EN
    logic [10:0] vel_bruta;
    assign vel_bruta = 11'(VEL_INIMIGA) + {4'b0, pontos[9:3]};
    assign vel       = (vel_bruta > 11'(VEL_MAX)) ? 11'(VEL_MAX) : vel_bruta;
`else
    assign vel = 11'(VEL_INIMIGA);
`endif

    assign y_soma = {1'b0, y_bola_inimiga} + vel;

    // One conditional subtraction suffices: 1023 - FAIXA_X < FAIXA_X
    assign lfsr_mod  = (lfsr >= 10'(FAIXA_X)) ? lfsr - 10'(FAIXA_X) : lfsr;
    assign x_respawn = lfsr_mod + 10'(MARGEM_X);

    assign raio_bola_inimiga = 10'(RAIO_INIMIGA);
    assign estado            = est;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            est            <= ESPERA;
            vidas          <= 2'(VIDAS_INI);
            pontos         <= '0;
            x_bola_inimiga <= 10'(LARGURA_TELA / 2);
            y_bola_inimiga <= 10'(Y_TOPO);
            reiniciarJogo  <= 1'b0;
            perdeu         <= 1'b0;
            lfsr           <= 10'h2A5;
            cnt_quadros    <= '0;
        end else begin
            lfsr          <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            reiniciarJogo <= 1'b0;
            case (est)
                ESPERA: begin
                    x_bola_inimiga <= 10'(LARGURA_TELA / 2);
                    y_bola_inimiga <= 10'(Y_TOPO);
                    if (iniciar) begin
                        est           <= JOGANDO;
                        reiniciarJogo <= 1'b1;
                        vidas         <= 2'(VIDAS_INI);
                        pontos        <= '0;
                    end
                end
                JOGANDO: begin
                    if (pausa) begin
                        est <= PAUSADO;
                    end else if (fim_quadro) begin
                        if (hit_nave) begin
                            vidas <= vidas - 2'd1;
                            if (vidas == 2'd1) begin
                                est    <= FIM;
                                perdeu <= 1'b1;
                            end else begin
                                est         <= ATINGIDO;
                                cnt_quadros <= '0;
                            end
                        end else if (hit_aliada) begin
                            if (pontos < 10'(PONTOS_MAX)) pontos <= pontos + 10'd1;
                            x_bola_inimiga <= x_respawn;
                            y_bola_inimiga <= 10'(Y_TOPO);
                        end else if (y_soma >= Y_LIMITE) begin
                            x_bola_inimiga <= x_respawn;
                            y_bola_inimiga <= 10'(Y_TOPO);
                        end else begin
                            y_bola_inimiga <= y_soma[9:0];
                        end
                    end
                end
                PAUSADO: begin
                    if (!pausa) est <= JOGANDO;
                end
                ATINGIDO: begin
                    if (fim_quadro) begin
                        if (cnt_quadros == 6'(QUADROS_HIT - 1)) begin
                            est            <= JOGANDO;
                            cnt_quadros    <= '0;
                            x_bola_inimiga <= x_respawn;
                            y_bola_inimiga <= 10'(Y_TOPO);
                        end else begin
                            cnt_quadros <= cnt_quadros + 6'd1;
                        end
                    end
                end
                FIM: begin
                    if (iniciar) begin
                        est            <= ESPERA;
                        perdeu         <= 1'b0;
                        x_bola_inimiga <= 10'(LARGURA_TELA / 2);
                        y_bola_inimiga <= 10'(Y_TOPO);
                    end
                end
                default: est <= ESPERA;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_jogo.sv
// tb/tb_controle_jogo.sv - table-driven and directed checks for controle_jogo
module tb_controle_jogo;

    logic       clk;
    logic       reset;
    logic       fim_quadro;
    logic       iniciar;
    logic       pausa;
    logic [9:0] x_bola_aliada, y_bola_aliada, raio_bola_aliada;
    logic [9:0] x_nave, y_nave, largura_nave, altura_nave;
    logic [9:0] x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
    logic       reiniciarJogo;
    logic       perdeu;
    logic [1:0] vidas;
    logic [9:0] pontos;
    logic [2:0] estado;

    int checks = 0;
    int errors = 0;

    controle_jogo dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .fim_quadro        (fim_quadro),
        .iniciar           (iniciar),
        .pausa             (pausa),
        .x_bola_aliada     (x_bola_aliada),
        .y_bola_aliada     (y_bola_aliada),
        .raio_bola_aliada  (raio_bola_aliada),
        .x_nave            (x_nave),
        .y_nave            (y_nave),
        .largura_nave      (largura_nave),
        .altura_nave       (altura_nave),
        .x_bola_inimiga    (x_bola_inimiga),
        .y_bola_inimiga    (y_bola_inimiga),
        .raio_bola_inimiga (raio_bola_inimiga),
        .reiniciarJogo     (reiniciarJogo),
        .perdeu            (perdeu),
        .vidas             (vidas),
        .pontos            (pontos),
        .estado            (estado)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int n;
        bit p;
        int ax, ay, ar;
        int ey, ep, est;
    } vec_t;

    vec_t tab[9];

    task automatic chk(input string nome, input int atual, input int esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic quadros(input int n);
        for (int i = 0; i < n; i++) begin
            fim_quadro = 1'b1;
            @(negedge clk);
            fim_quadro = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
    endtask

    initial begin
        reset = 1'b0; fim_quadro = 1'b0; iniciar = 1'b0; pausa = 1'b0;
        x_bola_aliada = 10'd1000; y_bola_aliada = 10'd1000; raio_bola_aliada = 10'd0;
        x_nave = 10'd1000; y_nave = 10'd1000; largura_nave = 10'd0; altura_nave = 10'd0;

        // n, pausa, ally x/y/r, expected y, pontos, estado
        tab[0] = '{10, 1'b0, 1000, 1000, 0, 40, 0, 1};
        tab[1] = '{1,  1'b0, 329,  40,   3, 42, 0, 1};
        tab[2] = '{1,  1'b0, 328,  42,   3, 20, 1, 1};
        tab[3] = '{1,  1'b0, 1000, 1000, 0, 22, 1, 1};
        tab[4] = '{5,  1'b1, 1000, 1000, 0, 22, 1, 2};
        tab[5] = '{0,  1'b0, 1000, 1000, 0, 22, 1, 1};
        tab[6] = '{1,  1'b0, 1000, 1000, 0, 24, 1, 1};
        tab[7] = '{225, 1'b0, 1000, 1000, 0, 474, 1, 1};
        tab[8] = '{1,  1'b0, 1000, 1000, 0, 20, 1, 1};

        repeat (3) @(negedge clk);
        chk("rst_estado", estado, 0);
        chk("rst_vidas", vidas, 3);
        chk("rst_pontos", pontos, 0);
        chk("rst_x", x_bola_inimiga, 320);
        chk("rst_y", y_bola_inimiga, 20);
        chk("rst_perdeu", perdeu, 0);
        chk("rst_reiniciar", reiniciarJogo, 0);
        chk("raio", raio_bola_inimiga, 5);
        reset = 1'b1;
        @(negedge clk);

        pulso_iniciar();
        chk("start_reiniciar_hi", reiniciarJogo, 1);
        chk("start_estado", estado, 1);
        @(negedge clk);
        chk("start_reiniciar_lo", reiniciarJogo, 0);
        chk("start_vidas", vidas, 3);
        chk("start_pontos", pontos, 0);
        chk("start_x", x_bola_inimiga, 320);
        chk("start_y", y_bola_inimiga, 20);

        for (int i = 0; i < 9; i++) begin
            x_bola_aliada = 10'(tab[i].ax);
            y_bola_aliada = 10'(tab[i].ay);
            raio_bola_aliada = 10'(tab[i].ar);
            pausa = tab[i].p;
            @(negedge clk);
            quadros(tab[i].n);
            chk($sformatf("vec%0d_y", i), y_bola_inimiga, tab[i].ey);
            chk($sformatf("vec%0d_pontos", i), pontos, tab[i].ep);
            chk($sformatf("vec%0d_estado", i), estado, tab[i].est);
            chk($sformatf("vec%0d_vidas", i), vidas, 3);
            if (i == 1) chk("near_miss_x", x_bola_inimiga, 320);
        end
        chk("respawn_x_range", int'(x_bola_inimiga >= 10 && x_bola_inimiga <= 629), 1);

        // Ship and allied ball both overlap: ship wins, no point
        x_nave = 10'd0; y_nave = 10'd0; largura_nave = 10'd1000; altura_nave = 10'd1000;
        x_bola_aliada = 10'd0; y_bola_aliada = 10'd0; raio_bola_aliada = 10'd1000;
        @(negedge clk);
        quadros(1);
        chk("hit1_vidas", vidas, 2);
        chk("hit1_pontos", pontos, 1);
        chk("hit1_estado", estado, 3);
        quadros(59);
        chk("hit1_59_estado", estado, 3);
        quadros(1);
        chk("hit1_60_estado", estado, 1);
        chk("hit1_60_y", y_bola_inimiga, 20);
        quadros(1);
        chk("hit2_vidas", vidas, 1);
        chk("hit2_estado", estado, 3);
        quadros(60);
        chk("hit2_60_estado", estado, 1);
        quadros(1);
        chk("hit3_vidas", vidas, 0);
        chk("hit3_estado", estado, 4);
        chk("hit3_perdeu", perdeu, 1);
        chk("hit3_pontos", pontos, 1);
        quadros(2);
        chk("fim_ignora_quadro", estado, 4);
        pulso_iniciar();
        chk("fim_sai_estado", estado, 0);
        chk("fim_sai_perdeu", perdeu, 0);
        chk("fim_sai_reiniciar", reiniciarJogo, 0);
        @(negedge clk);
        chk("espera_x", x_bola_inimiga, 320);
        chk("espera_y", y_bola_inimiga, 20);

        // Second game, then asynchronous reset while in ATINGIDO
        pulso_iniciar();
        chk("start2_reiniciar", reiniciarJogo, 1);
        chk("start2_vidas", vidas, 3);
        chk("start2_pontos", pontos, 0);
        quadros(1);
        chk("start2_hit_estado", estado, 3);
        quadros(10);
        #3 reset = 1'b0;
        #1;
        chk("async_estado", estado, 0);
        chk("async_vidas", vidas, 3);
        chk("async_pontos", pontos, 0);
        chk("async_x", x_bola_inimiga, 320);
        chk("async_y", y_bola_inimiga, 20);
        chk("async_reiniciar", reiniciarJogo, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("pos_reset_reiniciar", reiniciarJogo, 0);
        chk("pos_reset_estado", estado, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
